// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding and default widths.
package pipe_pkg;

    // Default payload: PC 32 + dest 5 + ALU 32 + mem 32
    localparam int PIPE_DATA_W = 101;
    // Default control sideband: write-select 2 + reg-enable 1
    localparam int PIPE_CTRL_W = 3;

    // Occupancy-coded state: the encoding doubles as the entry count
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // Upstream may be accepted in every state except FULL
    function automatic logic can_accept(input pipe_state_e st);
        return (st != ST_FULL);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with valid/ready handshakes,
// flush, and a registered upstream ready so OUT_READY never reaches IN_READY
// combinationally.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W            = PIPE_DATA_W,
    parameter int CTRL_W            = PIPE_CTRL_W,
    parameter bit FLUSH_CLEARS_DATA = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [CTRL_W-1:0] IN_CTRL,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [1:0]        OCC
);

    pipe_state_e       r_state;
    pipe_state_e       w_state_next;
    logic              r_in_ready;

    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic              w_out_valid;
    logic              w_in_xfer;
    logic              w_out_xfer;

    // Datapath steering decided by the FSM
    logic              w_main_from_in;
    logic              w_main_from_skid;
    logic              w_main_drain;
    logic              w_skid_from_in;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_xfer   = IN_VALID && r_in_ready;
    assign w_out_xfer  = w_out_valid && OUT_READY;

    // State register plus registered upstream ready (reset > flush > handshake)
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= can_accept(w_state_next);
        end
    end

    // Next-state logic; flush overrides every handshake outcome
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_EMPTY: if (w_in_xfer) w_state_next = ST_BUSY;
            ST_BUSY: begin
                if (w_in_xfer && !w_out_xfer)      w_state_next = ST_FULL;
                else if (!w_in_xfer && w_out_xfer) w_state_next = ST_EMPTY;
            end
            ST_FULL: if (w_out_xfer) w_state_next = ST_BUSY;
            default: w_state_next = ST_EMPTY;
        endcase
        if (FLUSH) w_state_next = ST_EMPTY;
    end

    // Datapath steering: which register loads from where this cycle
    always_comb begin
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_main_drain     = 1'b0;
        w_skid_from_in   = 1'b0;
        unique case (r_state)
            ST_EMPTY: w_main_from_in = w_in_xfer;
            ST_BUSY: begin
                w_main_from_in = w_in_xfer && w_out_xfer;
                w_skid_from_in = w_in_xfer && !w_out_xfer;
                w_main_drain   = !w_in_xfer && w_out_xfer;
            end
            ST_FULL: w_main_from_skid = w_out_xfer;
            default: ;
        endcase
    end

    // Main (head) register; control is cleared whenever the head leaves with nothing behind it
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
        end else if (FLUSH) begin
            r_main_ctrl <= '0;
            if (FLUSH_CLEARS_DATA) r_main_data <= '0;
        end else if (w_main_from_in) begin
            r_main_data <= IN_DATA;
            r_main_ctrl <= IN_CTRL;
        end else if (w_main_from_skid) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
        end else if (w_main_drain) begin
            r_main_ctrl <= '0;
            if (FLUSH_CLEARS_DATA) r_main_data <= '0;
        end
    end

    // Skid register: catches the entry that arrives while the head is stalled
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (FLUSH) begin
            r_skid_ctrl <= '0;
            if (FLUSH_CLEARS_DATA) r_skid_data <= '0;
        end else if (w_skid_from_in) begin
            r_skid_data <= IN_DATA;
            r_skid_ctrl <= IN_CTRL;
        end else if (w_main_from_skid) begin
            r_skid_ctrl <= '0;
            if (FLUSH_CLEARS_DATA) r_skid_data <= '0;
        end
    end

    // Output decode from registered state only
    always_comb begin
        IN_READY  = r_in_ready;
        OUT_VALID = w_out_valid;
        OUT_DATA  = r_main_data;
        OUT_CTRL  = w_out_valid ? r_main_ctrl : '0;
        OCC       = r_state;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table followed by a
// randomized run scored against a queue-based model.
module tb_pipe_stage_reg;

    localparam int DW = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occ;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W            (DW),
        .CTRL_W            (CW),
        .FLUSH_CLEARS_DATA (1'b0)
    ) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .FLUSH     (flush),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IN_DATA   (in_data),
        .IN_CTRL   (in_ctrl),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_DATA  (out_data),
        .OUT_CTRL  (out_ctrl),
        .OCC       (occ)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One directed step: inputs applied for one edge, expected outputs after it
    typedef struct {
        logic          rst_n;
        logic          flush;
        logic          iv;
        logic [DW-1:0] id;
        logic [CW-1:0] ic;
        logic          ordy;
        int            e_occ;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [CW-1:0] e_oc;
        logic          e_ir;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    vec_t vecs[$];
    ent_t q[$];

    task automatic add(input logic r, input logic f, input logic iv, input int id, input int ic,
                       input logic ordy, input int eocc, input logic eov, input int eod,
                       input int eoc, input logic eir);
        vec_t v;
        v.rst_n = r; v.flush = f; v.iv = iv; v.id = DW'(id); v.ic = CW'(ic); v.ordy = ordy;
        v.e_occ = eocc; v.e_ov = eov; v.e_od = DW'(eod); v.e_oc = CW'(eoc); v.e_ir = eir;
        vecs.push_back(v);
    endtask

    initial begin
        logic          m_in_xfer, m_out_xfer;
        logic [DW-1:0] last_head;
        ent_t          e;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_occ", int'(occ), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_out_ctrl", int'(out_ctrl), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", int'(in_ready), 1);

        //    rst flush iv   id   ic ordy occ ov  od   oc ir
        // streaming 1..4 at full throughput
        add(1, 0, 1, 8'h01, 1, 1, 1, 1, 8'h01, 1, 1);
        add(1, 0, 1, 8'h02, 2, 1, 1, 1, 8'h02, 2, 1);
        add(1, 0, 1, 8'h03, 3, 1, 1, 1, 8'h03, 3, 1);
        add(1, 0, 1, 8'h04, 4, 1, 1, 1, 8'h04, 4, 1);
        add(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h04, 0, 1);
        // stall: A into main, B into skid, offered C refused, then drain A, B
        add(1, 0, 1, 8'h10, 5, 0, 1, 1, 8'h10, 5, 1);
        add(1, 0, 1, 8'h20, 6, 0, 2, 1, 8'h10, 5, 0);
        add(1, 0, 1, 8'h30, 7, 0, 2, 1, 8'h10, 5, 0);
        add(1, 0, 0, 8'h00, 0, 1, 1, 1, 8'h20, 6, 1);
        add(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h20, 0, 1);
        // flush while FULL with an entry offered: offered entry never shows
        add(1, 0, 1, 8'h40, 1, 0, 1, 1, 8'h40, 1, 1);
        add(1, 0, 1, 8'h41, 2, 0, 2, 1, 8'h40, 1, 0);
        add(1, 1, 1, 8'h42, 3, 0, 0, 0, 8'h40, 0, 1);
        add(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h40, 0, 1);
        // flush together with an output transfer
        add(1, 0, 1, 8'h50, 7, 0, 1, 1, 8'h50, 7, 1);
        add(1, 1, 0, 8'h00, 0, 1, 0, 0, 8'h50, 0, 1);
        // reset while FULL, then resume
        add(1, 0, 1, 8'h60, 1, 0, 1, 1, 8'h60, 1, 1);
        add(1, 0, 1, 8'h61, 2, 0, 2, 1, 8'h60, 1, 0);
        add(0, 0, 1, 8'h62, 3, 1, 0, 0, 8'h00, 0, 1);
        add(1, 0, 1, 8'h70, 3, 1, 1, 1, 8'h70, 3, 1);
        add(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h70, 0, 1);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; flush = vecs[i].flush; in_valid = vecs[i].iv;
            in_data = vecs[i].id; in_ctrl = vecs[i].ic; out_ready = vecs[i].ordy;
            @(posedge clk); #1;
            $display("vec %0d: occ=%0d ov=%0b od=0x%0h oc=%0d ir=%0b", i, occ, out_valid, out_data, out_ctrl, in_ready);
            chk($sformatf("vec%0d_occ", i), int'(occ), vecs[i].e_occ);
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vecs[i].e_ov));
            chk($sformatf("vec%0d_out_data", i), int'(out_data), int'(vecs[i].e_od));
            chk($sformatf("vec%0d_out_ctrl", i), int'(out_ctrl), int'(vecs[i].e_oc));
            chk($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(vecs[i].e_ir));
        end

        // Hand sequence: stalled head stays stable for several cycles
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hA5; in_ctrl = 3'd6; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("stall_hold_data", int'(out_data), 8'hA5);
            chk("stall_hold_ctrl", int'(out_ctrl), 6);
        end

        // Randomized run from a clean reset against a queue model
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        last_head = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            chk("rnd_occ", int'(occ), q.size());
            chk("rnd_in_ready", int'(in_ready), (q.size() < 2) ? 1 : 0);
            chk("rnd_out_valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
            if (q.size() > 0) begin
                chk("rnd_out_data", int'(out_data), int'(q[0].d));
                chk("rnd_out_ctrl", int'(out_ctrl), int'(q[0].c));
            end else begin
                chk("rnd_idle_data", int'(out_data), int'(last_head));
                chk("rnd_idle_ctrl", int'(out_ctrl), 0);
            end

            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 2) != 0;
            in_data   = DW'($urandom);
            in_ctrl   = CW'($urandom);

            m_in_xfer  = in_valid && (q.size() < 2);
            m_out_xfer = out_ready && (q.size() > 0);
            if (cyc % 1000 == 0)
                $display("rnd cyc %0d: occ=%0d in=%0b out=%0b flush=%0b", cyc, q.size(), m_in_xfer, m_out_xfer, flush);
            if (flush) begin
                q.delete();
            end else begin
                if (m_out_xfer) void'(q.pop_front());
                if (m_in_xfer) begin
                    e.d = in_data; e.c = in_ctrl;
                    q.push_back(e);
                end
            end
            if (q.size() > 0) last_head = q[0].d;

            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
